// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Width of the stall_cycles statistics counter.
  localparam int CNT_W       = 16;
  // Width of the internal run-length and flush-length counters (DEPTH/TIMEOUT <= 255).
  localparam int SEQ_W       = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count up on inc, hold once all ones are reached, return to zero on clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/global_stall_ctrl.sv
// Global stall/flush controller for two parallel pipelines sharing one producer.
// A back-pressured output freezes everything in the same cycle; a stall that lasts
// too long, or an external request, triggers a DEPTH-cycle flush of both pipelines.
module global_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_valid_1,
  input  logic             out_valid_2,
  input  logic             ready_1,
  input  logic             ready_2,
  input  logic             flush_req,
  output logic             global_stall,
  output logic             flush_1,
  output logic             flush_2,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [SEQ_W-1:0] RUN_LAST   = SEQ_W'(TIMEOUT - 1);
  localparam logic [SEQ_W-1:0] FLUSH_LAST = SEQ_W'(DEPTH - 1);

  state_e           r_state,     w_state_nxt;
  logic [SEQ_W-1:0] r_run_cnt,   w_run_cnt_nxt;
  logic [SEQ_W-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic             r_timeout,   w_timeout_nxt;
  logic             w_blocked;
  logic             w_stall;
  logic             w_flush;

  assign w_blocked = (out_valid_1 & ~ready_1) | (out_valid_2 & ~ready_2);

  // Next-state, counter updates and same-cycle stall/flush outputs; reset overrides all.
  always_comb begin
    w_state_nxt     = r_state;
    w_run_cnt_nxt   = r_run_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_timeout_nxt   = r_timeout;
    w_stall         = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall     = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_stall = w_blocked;
        if (flush_req) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = '0;
        end else if (w_blocked) begin
          // The blocked RUN cycle is the first of the run, so STALL starts at 1.
          w_state_nxt   = STALL;
          w_run_cnt_nxt = SEQ_W'(1);
        end
      end
      STALL: begin
        w_stall = w_blocked;
        if (flush_req) begin
          w_state_nxt     = FLUSH;
          w_run_cnt_nxt   = '0;
          w_flush_cnt_nxt = '0;
        end else if (w_blocked) begin
          if (r_run_cnt == RUN_LAST) begin
            w_state_nxt     = FLUSH;
            w_timeout_nxt   = 1'b1;
            w_run_cnt_nxt   = '0;
            w_flush_cnt_nxt = '0;
          end else begin
            w_run_cnt_nxt = r_run_cnt + SEQ_W'(1);
          end
        end else begin
          w_state_nxt   = RUN;
          w_run_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        w_stall = 1'b1;
        w_flush = 1'b1;
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nxt     = RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + SEQ_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (reset) begin
      w_state_nxt     = IDLE;
      w_run_cnt_nxt   = '0;
      w_flush_cnt_nxt = '0;
      w_timeout_nxt   = 1'b0;
      w_stall         = 1'b0;
      w_flush         = 1'b0;
    end
  end

  // Register state, counters and the sticky timeout flag.
  always_ff @(posedge clk) begin
    r_state     <= w_state_nxt;
    r_run_cnt   <= w_run_cnt_nxt;
    r_flush_cnt <= w_flush_cnt_nxt;
    r_timeout   <= w_timeout_nxt;
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .inc  (w_stall),
    .clr  (reset),
    .count(stall_cycles)
  );

  assign global_stall = w_stall;
  assign flush_1      = w_flush;
  assign flush_2      = w_flush;
  assign timeout      = r_timeout;

endmodule
